// File: rtl/popcount_acc_pipe.sv
// popcount_acc_pipe: two-stage pipelined population counter.
// Stage 1 compresses each 7-bit group to a 3-bit count. Stage 2 sums the
// group counts and either emits them per beat (mode 0) or accumulates them
// across a frame (mode 1), saturating at the accumulator's maximum value.
// The whole pipe advances together whenever the output slot is free or
// is being drained.

// 7:3 compressor: three full adders reduce 7 equal-weight bits to a count.
module popcnt7 (
  input  logic [6:0] d,
  output logic [2:0] c
);
  logic s_a, c_a, s_b, c_b, c_c;

  assign s_a  = d[0] ^ d[1] ^ d[2];
  assign c_a  = (d[0] & d[1]) | (d[0] & d[2]) | (d[1] & d[2]);
  assign s_b  = d[3] ^ d[4] ^ d[5];
  assign c_b  = (d[3] & d[4]) | (d[3] & d[5]) | (d[4] & d[5]);
  assign c[0] = s_a ^ s_b ^ d[6];
  assign c_c  = (s_a & s_b) | (s_a & d[6]) | (s_b & d[6]);
  assign c[1] = c_a ^ c_b ^ c_c;
  assign c[2] = (c_a & c_b) | (c_a & c_c) | (c_b & c_c);
endmodule

module popcount_acc_pipe #(
  parameter int IN_W  = 64,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int NG    = (IN_W + 6) / 7;
  localparam int PAD_W = NG * 7;

  if (IN_W < 1) begin : g_chk_in
    $error("IN_W must be at least 1");
  end
  if (ACC_W < CNT_W) begin : g_chk_acc
    $error("ACC_W must be >= clog2(IN_W+1)");
  end

  logic                  adv, accept;
  logic [PAD_W-1:0]      in_pad;
  logic [NG-1:0][2:0]    grp_cnt;

  // frame tracking (input side)
  logic                  frame_first, frame_mode, eff_mode, frame_end;

  // stage 1 registers
  logic                  s1_valid, s1_last, s1_mode, s1_first;
  logic [NG-1:0][2:0]    s1_cnt;

  // stage 2 datapath and state
  logic [CNT_W-1:0]      cnt_sum;
  logic [ACC_W-1:0]      acc, base, result;
  logic [ACC_W:0]        sum;
  logic                  acc_sat, sat_now, produce;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Upper group is zero-padded so pad bits can never contribute to the count.
  assign in_pad = PAD_W'(in_data);

  for (genvar g = 0; g < NG; g++) begin : g_grp
    popcnt7 u_pc (.d(in_pad[g*7 +: 7]), .c(grp_cnt[g]));
  end

  // mode is only honoured on the first beat; later beats inherit the frame's.
  assign eff_mode  = frame_first ? mode : frame_mode;
  assign frame_end = !eff_mode || in_last;

  // Frame state: remember the frame's mode and whether the next beat opens a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_first <= 1'b1;
      frame_mode  <= 1'b0;
    end else if (accept) begin
      if (frame_first) frame_mode <= mode;
      frame_first <= frame_end;
    end
  end

  // Stage 1: capture group counts and per-beat frame attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
      s1_first <= 1'b0;
      s1_cnt   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_mode  <= eff_mode;
      s1_first <= frame_first;
      s1_cnt   <= grp_cnt;
    end
  end

  // Stage 2 combinational: sum groups, add to running total, clamp on overflow.
  always_comb begin
    cnt_sum = '0;
    for (int g = 0; g < NG; g++) cnt_sum = cnt_sum + CNT_W'(s1_cnt[g]);
    base    = s1_first ? '0 : acc;
    sum     = {1'b0, base} + (ACC_W+1)'(cnt_sum);
    // Once a frame has saturated it stays pinned at the maximum.
    sat_now = (!s1_first && acc_sat) || sum[ACC_W];
    result  = sat_now ? '1 : sum[ACC_W-1:0];
    produce = !s1_mode || s1_last;
  end

  // Stage 2 registers: accumulator on every beat, output only on frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid && produce;
      out_sat   <= s1_valid && produce && sat_now;
      if (s1_valid) begin
        acc     <= result;
        acc_sat <= sat_now;
        if (produce) out_count <= result;
      end
    end
  end
endmodule

// File: tb/tb_popcount_acc_pipe.sv
// Bench for popcount_acc_pipe: directed vectors with hand-computed results
// pushed to per-DUT queues; monitors pop and compare on every transfer.
// DUT a: IN_W=64, ACC_W=8 (saturation reachable). DUT b: IN_W=10 (padded group).
module tb_popcount_acc_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        va = 1'b0, la = 1'b0, ma = 1'b0, ora = 1'b1;
  logic [63:0] da = '0;
  logic        ira, ova, osa;
  logic [7:0]  oca;

  logic        vb = 1'b0, lb = 1'b0, mb = 1'b0, orb = 1'b1;
  logic [9:0]  db = '0;
  logic        irb, ovb, osb;
  logic [15:0] ocb;

  popcount_acc_pipe #(.IN_W(64), .ACC_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ira), .in_data(da),
    .in_last(la), .mode(ma), .out_valid(ova), .out_ready(ora),
    .out_count(oca), .out_sat(osa));

  popcount_acc_pipe #(.IN_W(10), .ACC_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(irb), .in_data(db),
    .in_last(lb), .mode(mb), .out_valid(ovb), .out_ready(orb),
    .out_count(ocb), .out_sat(osb));

  typedef struct { int cnt; bit sat; } exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int n_chk = 0, n_fail = 0;
  int bp_a = 0;  // 0: always ready, 1: random ready, 2: stalled

  function automatic void chk(string nm, bit ok, longint act, longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // downstream backpressure for DUT a
  always @(negedge clk)
    ora = (bp_a == 0) ? 1'b1 : (bp_a == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

  // monitor a
  logic pva = 0, pra = 0, psa = 0;
  logic [7:0] pca = '0;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("in_ready_a", ira == (!ova || ora), ira, !ova || ora);
      if (!ova) chk("sat_idle_a", osa == 1'b0, osa, 0);
      if (pva && !pra) chk("stall_hold_a", ova && oca == pca && osa == psa, oca, pca);
      if (ova && ora) begin
        if (qa.size() == 0) chk("unexpected_a", 1'b0, oca, -1);
        else begin
          ea = qa.pop_front();
          chk("count_a", oca == ea.cnt, oca, ea.cnt);
          chk("sat_a", osa == ea.sat, osa, ea.sat);
        end
      end
    end
    pva = ova; pra = ora; pca = oca; psa = osa;
  end

  // monitor b
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("in_ready_b", irb == (!ovb || orb), irb, !ovb || orb);
      if (!ovb) chk("sat_idle_b", osb == 1'b0, osb, 0);
      if (ovb && orb) begin
        if (qb.size() == 0) chk("unexpected_b", 1'b0, ocb, -1);
        else begin
          eb = qb.pop_front();
          chk("count_b", ocb == eb.cnt, ocb, eb.cnt);
          chk("sat_b", osb == eb.sat, osb, eb.sat);
        end
      end
    end
  end

  task automatic send_a(input logic [63:0] d, input logic l, input logic m,
                        input bit push, input int ec, input bit es);
    int t = 0;
    @(negedge clk); va = 1'b1; da = d; la = l; ma = m;
    #1;
    while (!ira && t < 1000) begin @(negedge clk); #1; t++; end
    if (t >= 1000) chk("in_ready_timeout_a", 1'b0, 0, 1);
    if (push) qa.push_back('{cnt: ec, sat: es});
    @(posedge clk);
  endtask

  task automatic send_b(input logic [9:0] d, input logic l, input logic m,
                        input bit push, input int ec);
    int t = 0;
    @(negedge clk); vb = 1'b1; db = d; lb = l; mb = m;
    #1;
    while (!irb && t < 1000) begin @(negedge clk); #1; t++; end
    if (t >= 1000) chk("in_ready_timeout_b", 1'b0, 0, 1);
    if (push) qb.push_back('{cnt: ec, sat: 1'b0});
    @(posedge clk);
  endtask

  task automatic idle;
    @(negedge clk); va = 1'b0; vb = 1'b0;
  endtask

  task automatic drain;
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 2000) begin @(posedge clk); t++; end
    chk("drain", qa.size() == 0 && qb.size() == 0, qa.size() + qb.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_rst;
    @(negedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", ova == 1'b0, ova, 0);
    chk("rst_out_count", oca == 8'd0, oca, 0);
    chk("rst_out_sat", osa == 1'b0, osa, 0);
    chk("rst_in_ready", ira == 1'b1, ira, 1);
    rst = 1'b0;

    // mode 0, latency of two cycles
    send_a(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1, 64, 0);
    @(negedge clk); va = 1'b0; #1;
    chk("latency_1cyc_low", ova == 1'b0, ova, 0);
    @(negedge clk); #1;
    chk("latency_2cyc_high", ova == 1'b1, ova, 1);
    send_a(64'h81, 1'b0, 1'b0, 1, 2, 0);
    send_a(64'h0, 1'b1, 1'b0, 1, 0, 0);
    idle(); drain();

    // mode 1, three beats 10+20+30, one result only
    send_a(64'h3FF, 1'b0, 1'b1, 0, 0, 0);
    send_a(64'hF_FFFF, 1'b0, 1'b1, 0, 0, 0);
    send_a(64'h3FFF_FFFF, 1'b1, 1'b1, 1, 60, 0);
    idle(); drain();

    // saturation: 5 x 64 into 8 bits, then a fresh small frame
    for (int i = 0; i < 5; i++)
      send_a(64'hFFFF_FFFF_FFFF_FFFF, i == 4, 1'b1, i == 4, 255, 1);
    send_a(64'h7, 1'b1, 1'b1, 1, 3, 0);
    idle(); drain();

    // backpressure during a mode-1 frame, then random mode-0 stream
    bp_a = 1;
    send_a(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0, 0, 0);
    send_a(64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, 0, 0);
    send_a(64'h0000_0001_0000_0001, 1'b1, 1'b1, 1, 67, 0);
    for (int i = 0; i < 100; i++) begin
      d = {$urandom, $urandom};
      send_a(d, 1'($urandom_range(0, 1)), 1'b0, 1, $countones(d), 0);
    end
    idle(); drain();
    bp_a = 0;

    // reset aborts an open mode-1 frame; next frame restarts from 0
    send_a(64'hF_FFFF, 1'b0, 1'b1, 0, 0, 0);
    send_a(64'hF_FFFF_0000_0000, 1'b0, 1'b1, 0, 0, 0);
    idle();
    repeat (2) @(posedge clk);
    pulse_rst();
    send_a(64'h1F, 1'b1, 1'b1, 1, 5, 0);
    idle(); drain();

    // reset while a result is held under backpressure discards it
    bp_a = 2;
    send_a(64'hFF, 1'b0, 1'b0, 0, 0, 0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("held_result_valid", ova == 1'b1 && oca == 8'd8, oca, 8);
    pulse_rst();
    chk("rst_drops_result", ova == 1'b0, ova, 0);
    bp_a = 0;
    send_a(64'h7, 1'b0, 1'b0, 1, 3, 0);
    idle(); drain();

    // IN_W=10: mode flip mid-frame ignored, pad bits never counted
    send_b(10'h07F, 1'b0, 1'b1, 0, 0);
    send_b(10'h007, 1'b1, 1'b0, 1, 10);
    send_b(10'h3FF, 1'b0, 1'b0, 1, 10);
    send_b(10'h001, 1'b0, 1'b0, 1, 1);
    idle(); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
